// File: rtl/wb_burst_master.sv
// wb_burst_master
//   Wishbone B3 initiator. Turns a command/stream interface into a classic
//   single access or a linear incrementing burst on the Wishbone bus.
//
// Ports
//   wb_clk_i, wb_rst_i     clock (rising edge), synchronous active-low reset
//   cmd_*                  command handshake: direction, start word address,
//                          beats-minus-one, byte select used on every beat
//   wdat_valid_i/wdat_i    write data stream (held stable until consumed)
//   wdat_ready_o           write beat consumed this cycle
//   rdat_valid_o/rdat_o    read data stream, one cycle after the ack beat
//   done_o/err_o           end-of-transaction pulse, err_o flags an abort
//   wb_*                   Wishbone B3 initiator port (bte fixed to linear)
module wb_burst_master #(
    parameter  int DW      = 32,
    parameter  int AW      = 32,
    parameter  int LW      = 4,
    localparam int SW      = DW / 8,
    localparam int BYTE_AW = SW >> 1,
    localparam int WORD_AW = AW - BYTE_AW
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_we_i,
    input  logic [WORD_AW-1:0] cmd_addr_i,
    input  logic [LW-1:0]      cmd_len_i,
    input  logic [SW-1:0]      cmd_sel_i,
    input  logic               wdat_valid_i,
    input  logic [DW-1:0]      wdat_i,
    output logic               wdat_ready_o,
    output logic               rdat_valid_o,
    output logic [DW-1:0]      rdat_o,
    output logic               done_o,
    output logic               err_o,
    output logic [AW-1:0]      wb_adr_o,
    output logic [1:0]         wb_bte_o,
    output logic [2:0]         wb_cti_o,
    output logic               wb_cyc_o,
    output logic               wb_stb_o,
    output logic               wb_we_o,
    output logic [SW-1:0]      wb_sel_o,
    output logic [DW-1:0]      wb_dat_o,
    input  logic               wb_ack_i,
    input  logic               wb_err_i,
    input  logic               wb_rty_i,
    input  logic [DW-1:0]      wb_dat_i
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUS  = 1'b1;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    logic [0:0]         state_reg;
    logic [WORD_AW-1:0] adr_reg;
    logic [LW-1:0]      cnt_reg;
    logic [2:0]         cti_reg;
    logic               we_reg;
    logic [SW-1:0]      sel_reg;
    logic               rdat_valid_reg;
    logic [DW-1:0]      rdat_reg;
    logic               done_reg;
    logic               err_reg;

    logic cyc;
    logic stb;
    logic abort;
    logic beat;

    // The FSM state doubles as the registered cyc output.
    assign cyc   = (state_reg == ST_BUS);
    // A write without data present becomes a master wait state.
    assign stb   = cyc & (~we_reg | wdat_valid_i);
    // err/rty outrank a simultaneous ack: that beat is neither counted
    // nor delivered.
    assign abort = stb & (wb_err_i | wb_rty_i);
    assign beat  = stb & wb_ack_i & ~wb_err_i & ~wb_rty_i;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_reg      <= ST_IDLE;
            adr_reg        <= '0;
            cnt_reg        <= '0;
            cti_reg        <= CTI_CLASSIC;
            we_reg         <= 1'b0;
            sel_reg        <= '0;
            rdat_valid_reg <= 1'b0;
            rdat_reg       <= '0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            rdat_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        state_reg <= ST_BUS;
                        adr_reg   <= cmd_addr_i;
                        we_reg    <= cmd_we_i;
                        sel_reg   <= cmd_sel_i;
                        cnt_reg   <= cmd_len_i;
                        cti_reg   <= (cmd_len_i == '0) ? CTI_CLASSIC : CTI_INCR;
                    end
                end
                ST_BUS: begin
                    if (abort) begin
                        state_reg <= ST_IDLE;
                        we_reg    <= 1'b0;
                        done_reg  <= 1'b0 | 1'b1;
                        err_reg   <= 1'b1;
                    end else if (beat) begin
                        if (!we_reg) begin
                            rdat_valid_reg <= 1'b1;
                            rdat_reg       <= wb_dat_i;
                        end
                        if (cnt_reg == '0) begin
                            state_reg <= ST_IDLE;
                            we_reg    <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                            // Word address wraps naturally at 2^WORD_AW.
                            adr_reg <= adr_reg + 1'b1;
                            // Counter about to reach zero: next beat is last.
                            if (cnt_reg == LW'(1)) begin
                                cti_reg <= CTI_END;
                            end
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready_o  = (state_reg == ST_IDLE);
    assign wdat_ready_o = beat & we_reg;
    assign rdat_valid_o = rdat_valid_reg;
    assign rdat_o       = rdat_reg;
    assign done_o       = done_reg;
    assign err_o        = err_reg;

    assign wb_adr_o = AW'(adr_reg) << BYTE_AW;
    assign wb_bte_o = 2'b00;
    assign wb_cti_o = cti_reg;
    assign wb_cyc_o = cyc;
    assign wb_stb_o = stb;
    assign wb_we_o  = we_reg;
    assign wb_sel_o = sel_reg;
    assign wb_dat_o = wdat_i;

endmodule

// File: tb/tb_wb_burst_master.sv
// Testbench for wb_burst_master: a table of per-cycle vectors for the directed
// scenarios, a hand-written wrap/back-to-back sequence on an AW=8 instance,
// and randomized transactions checked against a transaction-level model.
module tb_wb_burst_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: DW=32, AW=32, LW=4
    logic        rst_n, cmd_valid, cmd_ready, cmd_we;
    logic [29:0] cmd_addr;
    logic [3:0]  cmd_len, cmd_sel;
    logic        wdat_valid, wdat_ready, rdat_valid, done, err;
    logic [31:0] wdat, rdat, adr, dat_o, dat_i;
    logic [1:0]  bte;
    logic [2:0]  cti;
    logic        cyc, stb, we, ack, werr, rty;
    logic [3:0]  sel;

    wb_burst_master #(.DW(32), .AW(32), .LW(4)) u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_sel_i(cmd_sel),
        .wdat_valid_i(wdat_valid), .wdat_i(wdat), .wdat_ready_o(wdat_ready),
        .rdat_valid_o(rdat_valid), .rdat_o(rdat), .done_o(done), .err_o(err),
        .wb_adr_o(adr), .wb_bte_o(bte), .wb_cti_o(cti), .wb_cyc_o(cyc),
        .wb_stb_o(stb), .wb_we_o(we), .wb_sel_o(sel), .wb_dat_o(dat_o),
        .wb_ack_i(ack), .wb_err_i(werr), .wb_rty_i(rty), .wb_dat_i(dat_i)
    );

    // Second instance: AW=8 for the address-wrap scenario
    logic        rst8_n, cv8, rdy8, cwe8, wv8, wrdy8, rv8, done8, err8;
    logic [5:0]  addr8;
    logic [3:0]  len8, csel8, sel8;
    logic [31:0] wdat8, rdat8, dato8, dati8;
    logic [7:0]  adr8;
    logic [1:0]  bte8;
    logic [2:0]  cti8;
    logic        cyc8, stb8, we8, ack8, werr8, rty8;

    wb_burst_master #(.DW(32), .AW(8), .LW(4)) u_dut8 (
        .wb_clk_i(clk), .wb_rst_i(rst8_n),
        .cmd_valid_i(cv8), .cmd_ready_o(rdy8), .cmd_we_i(cwe8),
        .cmd_addr_i(addr8), .cmd_len_i(len8), .cmd_sel_i(csel8),
        .wdat_valid_i(wv8), .wdat_i(wdat8), .wdat_ready_o(wrdy8),
        .rdat_valid_o(rv8), .rdat_o(rdat8), .done_o(done8), .err_o(err8),
        .wb_adr_o(adr8), .wb_bte_o(bte8), .wb_cti_o(cti8), .wb_cyc_o(cyc8),
        .wb_stb_o(stb8), .wb_we_o(we8), .wb_sel_o(sel8), .wb_dat_o(dato8),
        .wb_ack_i(ack8), .wb_err_i(werr8), .wb_rty_i(rty8), .wb_dat_i(dati8)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst_n, cv, we;
        logic [29:0] addr;
        logic [3:0]  len;
        logic        wv, ack, err;
        logic [31:0] rd;
        logic        e_rdy, e_cyc, e_stb;
        logic [31:0] e_adr;
        logic [2:0]  e_cti;
        logic        e_wrdy, e_rv;
        logic [31:0] e_rdat;
        logic        e_done, e_err;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, cv, w, input logic [29:0] a, input logic [3:0] l,
                       input logic wv, ak, er, input logic [31:0] rd,
                       input logic rdy, cy, st, input logic [31:0] ad, input logic [2:0] ct,
                       input logic wr, rv, input logic [31:0] rdt, input logic dn, ee);
        vec_t v;
        v = '{r, cv, w, a, l, wv, ak, er, rd, rdy, cy, st, ad, ct, wr, rv, rdt, dn, ee};
        vq.push_back(v);
    endtask

    // Random-test state
    logic        tr_we;
    logic [29:0] tr_addr, wa;
    logic [3:0]  tr_len, tr_sel;
    logic        exp_stb, finished, aborted, pend_rv;
    logic [31:0] pend_dat;
    int          k, r;

    initial begin
        rst_n = 0; cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_len = '0; cmd_sel = 4'hF;
        wdat_valid = 0; wdat = '0; ack = 0; werr = 0; rty = 0; dat_i = '0;
        rst8_n = 0; cv8 = 0; cwe8 = 0; addr8 = '0; len8 = '0; csel8 = 4'hF;
        wv8 = 0; wdat8 = '0; ack8 = 0; werr8 = 0; rty8 = 0; dati8 = '0;

        // ---------------- vector table ----------------
        // Read, addr 0x10, single beat
        add(1,1,0,30'h10,0,  0,0,0,0,            1,0,0,0,0,       0,0,0,0,0);
        add(1,0,0,0,0,       0,1,0,32'hA5A50001, 0,1,1,32'h40,0,  0,0,0,0,0);
        add(1,0,0,0,0,       0,0,0,0,            1,0,0,0,0,       0,1,32'hA5A50001,1,0);
        add(1,0,0,0,0,       0,0,0,0,            1,0,0,0,0,       0,0,0,0,0);
        // Write burst, addr 0x100, 4 beats, data always valid
        add(1,1,1,30'h100,3, 1,0,0,0,            1,0,0,0,0,       0,0,0,0,0);
        add(1,0,1,0,0,       1,1,0,0,            0,1,1,32'h400,2, 1,0,0,0,0);
        add(1,0,1,0,0,       1,1,0,0,            0,1,1,32'h404,2, 1,0,0,0,0);
        add(1,0,1,0,0,       1,1,0,0,            0,1,1,32'h408,2, 1,0,0,0,0);
        add(1,0,1,0,0,       1,1,0,0,            0,1,1,32'h40C,7, 1,0,0,0,0);
        add(1,0,0,0,0,       0,0,0,0,            1,0,0,0,0,       0,0,0,1,0);
        // Same write, data missing for 2 cycles after beat 1 (acks then ignored)
        add(1,1,1,30'h100,3, 1,0,0,0,            1,0,0,0,0,       0,0,0,0,0);
        add(1,0,1,0,0,       1,1,0,0,            0,1,1,32'h400,2, 1,0,0,0,0);
        add(1,0,1,0,0,       0,1,0,0,            0,1,0,32'h404,2, 0,0,0,0,0);
        add(1,0,1,0,0,       0,1,0,0,            0,1,0,32'h404,2, 0,0,0,0,0);
        add(1,0,1,0,0,       1,1,0,0,            0,1,1,32'h404,2, 1,0,0,0,0);
        add(1,0,1,0,0,       1,1,0,0,            0,1,1,32'h408,2, 1,0,0,0,0);
        add(1,0,1,0,0,       1,1,0,0,            0,1,1,32'h40C,7, 1,0,0,0,0);
        add(1,0,0,0,0,       0,0,0,0,            1,0,0,0,0,       0,0,0,1,0);
        // Read len 7, error on 3rd beat
        add(1,1,0,30'h80,7,  0,0,0,0,            1,0,0,0,0,       0,0,0,0,0);
        add(1,0,0,0,0,       0,1,0,32'h11110000, 0,1,1,32'h200,2, 0,0,0,0,0);
        add(1,0,0,0,0,       0,1,0,32'h22220001, 0,1,1,32'h204,2, 0,1,32'h11110000,0,0);
        add(1,0,0,0,0,       0,0,1,32'h33330002, 0,1,1,32'h208,2, 0,1,32'h22220001,0,0);
        add(1,0,0,0,0,       0,0,0,0,            1,0,0,0,0,       0,0,0,1,1);
        add(1,0,0,0,0,       0,0,0,0,            1,0,0,0,0,       0,0,0,0,0);
        // 16-beat read, reset mid burst, then a fresh command
        add(1,1,0,30'h20,15, 0,0,0,0,            1,0,0,0,0,       0,0,0,0,0);
        add(1,0,0,0,0,       0,1,0,32'h44440000, 0,1,1,32'h80,2,  0,0,0,0,0);
        add(1,0,0,0,0,       0,1,0,32'h44440001, 0,1,1,32'h84,2,  0,1,32'h44440000,0,0);
        add(1,0,0,0,0,       0,1,0,32'h44440002, 0,1,1,32'h88,2,  0,1,32'h44440001,0,0);
        add(0,0,0,0,0,       0,0,0,0,            0,1,1,32'h8C,2,  0,1,32'h44440002,0,0);
        add(1,1,0,30'h7,0,   0,0,0,0,            1,0,0,0,0,       0,0,0,0,0);
        add(1,0,0,0,0,       0,1,0,32'h55550000, 0,1,1,32'h1C,0,  0,0,0,0,0);
        add(1,0,0,0,0,       0,0,0,0,            1,0,0,0,0,       0,1,32'h55550000,1,0);

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_cyc", 32'(cyc), 0);   chk("rst_stb", 32'(stb), 0);
        chk("rst_we", 32'(we), 0);     chk("rst_adr", adr, 0);
        chk("rst_sel", 32'(sel), 0);   chk("rst_cti", 32'(cti), 0);
        chk("rst_rdat", rdat, 0);      chk("rst_rv", 32'(rdat_valid), 0);
        chk("rst_done", 32'(done), 0); chk("rst_err", 32'(err), 0);
        chk("rst_rdy", 32'(cmd_ready), 1); chk("rst_bte", 32'(bte), 0);
        rst_n = 1; rst8_n = 1;

        // ---------------- apply table ----------------
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst_n = vq[i].rst_n; cmd_valid = vq[i].cv; cmd_we = vq[i].we;
            cmd_addr = vq[i].addr; cmd_len = vq[i].len; cmd_sel = 4'hF;
            wdat_valid = vq[i].wv; wdat = 32'hD0000000 + 32'(i);
            ack = vq[i].ack; werr = vq[i].err; rty = 0; dat_i = vq[i].rd;
            #1;
            chk($sformatf("v%0d_rdy", i),  32'(cmd_ready),  32'(vq[i].e_rdy));
            chk($sformatf("v%0d_cyc", i),  32'(cyc),        32'(vq[i].e_cyc));
            chk($sformatf("v%0d_stb", i),  32'(stb),        32'(vq[i].e_stb));
            chk($sformatf("v%0d_wrdy", i), 32'(wdat_ready), 32'(vq[i].e_wrdy));
            chk($sformatf("v%0d_rv", i),   32'(rdat_valid), 32'(vq[i].e_rv));
            chk($sformatf("v%0d_done", i), 32'(done),       32'(vq[i].e_done));
            chk($sformatf("v%0d_err", i),  32'(err),        32'(vq[i].e_err));
            if (vq[i].e_cyc) begin
                chk($sformatf("v%0d_adr", i), adr, vq[i].e_adr);
                chk($sformatf("v%0d_cti", i), 32'(cti), 32'(vq[i].e_cti));
            end
            if (vq[i].e_rv) chk($sformatf("v%0d_rdat", i), rdat, vq[i].e_rdat);
            $display("vec %0d: cyc=%0b stb=%0b adr=%h cti=%0d done=%0b err=%0b",
                     i, cyc, stb, adr, cti, done, err);
        end
        @(negedge clk);
        rst_n = 1; cmd_valid = 0; ack = 0; werr = 0; wdat_valid = 0;

        // ---------------- AW=8: wrap and back-to-back commands ----------------
        @(negedge clk); cv8 = 1; addr8 = 6'h3F; len8 = 1; cwe8 = 0; #1;
        chk("w8_rdy0", 32'(rdy8), 1); chk("w8_cyc0", 32'(cyc8), 0);
        @(negedge clk); cv8 = 0; ack8 = 1; dati8 = 32'hCAFE0001; #1;
        chk("w8_cyc1", 32'(cyc8), 1); chk("w8_adr1", 32'(adr8), 32'hFC); chk("w8_cti1", 32'(cti8), 2);
        @(negedge clk); cv8 = 1; addr8 = 6'h10; len8 = 0; ack8 = 1; dati8 = 32'hCAFE0002; #1;
        chk("w8_cyc2", 32'(cyc8), 1); chk("w8_adr2", 32'(adr8), 0); chk("w8_cti2", 32'(cti8), 7);
        chk("w8_rdy2", 32'(rdy8), 0); chk("w8_rdat2", rdat8, 32'hCAFE0001);
        @(negedge clk); ack8 = 0; #1;
        chk("w8_cyc3", 32'(cyc8), 0); chk("w8_done3", 32'(done8), 1); chk("w8_err3", 32'(err8), 0);
        chk("w8_rdy3", 32'(rdy8), 1); chk("w8_rdat3", rdat8, 32'hCAFE0002);
        @(negedge clk); cv8 = 0; ack8 = 1; dati8 = 32'hCAFE0003; #1;
        chk("w8_cyc4", 32'(cyc8), 1); chk("w8_adr4", 32'(adr8), 32'h40); chk("w8_cti4", 32'(cti8), 0);
        @(negedge clk); ack8 = 0; #1;
        chk("w8_cyc5", 32'(cyc8), 0); chk("w8_done5", 32'(done8), 1);
        $display("aw8 seq: done, wrap and back-to-back checked");

        // ---------------- randomized transactions ----------------
        for (int t = 0; t < 150; t++) begin
            tr_we   = 1'($urandom_range(0, 1));
            tr_addr = ($urandom_range(0, 3) == 0) ? (30'h3FFFFFFF - 30'($urandom_range(0, 4)))
                                                  : 30'($urandom);
            tr_len  = 4'($urandom_range(0, 15));
            tr_sel  = 4'($urandom_range(1, 15));
            @(negedge clk);
            cmd_valid = 1; cmd_we = tr_we; cmd_addr = tr_addr; cmd_len = tr_len; cmd_sel = tr_sel;
            ack = 0; werr = 0; rty = 0; wdat_valid = 1'($urandom_range(0, 1));
            #1;
            chk("rnd_accept_rdy", 32'(cmd_ready), 1);
            chk("rnd_accept_cyc", 32'(cyc), 0);
            chk("rnd_accept_done", 32'(done), 0);
            k = 0; finished = 0; aborted = 0; pend_rv = 0; pend_dat = '0;
            for (int c = 0; c < 400 && !finished; c++) begin
                @(negedge clk);
                // Commands offered mid-transaction must be ignored.
                cmd_valid = 1'($urandom_range(0, 1)); cmd_we = 1'($urandom_range(0, 1));
                cmd_addr = 30'($urandom); cmd_len = 4'($urandom);
                wdat_valid = ($urandom_range(0, 3) != 0); wdat = $urandom; dat_i = $urandom;
                r = $urandom_range(0, 99);
                ack  = (r < 65) || (r >= 96);
                werr = (r >= 92 && r < 94) || (r >= 98);
                rty  = (r >= 94 && r < 98);
                #1;
                exp_stb = tr_we ? wdat_valid : 1'b1;
                wa = tr_addr + 30'(k);
                chk("rnd_cyc", 32'(cyc), 1);
                chk("rnd_rdy", 32'(cmd_ready), 0);
                chk("rnd_stb", 32'(stb), 32'(exp_stb));
                chk("rnd_we", 32'(we), 32'(tr_we));
                chk("rnd_sel", 32'(sel), 32'(tr_sel));
                chk("rnd_adr", adr, {wa, 2'b00});
                chk("rnd_cti", 32'(cti), (tr_len == 0) ? 0 : ((k == int'(tr_len)) ? 7 : 2));
                chk("rnd_dat_o", dat_o, wdat);
                chk("rnd_wrdy", 32'(wdat_ready), 32'(tr_we && exp_stb && ack && !werr && !rty));
                chk("rnd_done", 32'(done), 0);
                chk("rnd_rv", 32'(rdat_valid), 32'(pend_rv));
                if (pend_rv) chk("rnd_rdat", rdat, pend_dat);
                pend_rv = 0;
                if (exp_stb && (werr || rty)) begin
                    aborted = 1; finished = 1;
                end else if (exp_stb && ack) begin
                    if (!tr_we) begin pend_rv = 1; pend_dat = dat_i; end
                    if (k == int'(tr_len)) finished = 1;
                    else k++;
                end
            end
            if (!finished) begin
                checks++; failures++;
                $display("FAIL rnd_timeout actual=busy required=finished (txn %0d)", t);
            end
            @(negedge clk);
            cmd_valid = 0; ack = 1'($urandom_range(0, 1)); werr = 0; rty = 0; wdat_valid = 0;
            #1;
            chk("rnd_end_cyc", 32'(cyc), 0);
            chk("rnd_end_rdy", 32'(cmd_ready), 1);
            chk("rnd_end_done", 32'(done), 1);
            chk("rnd_end_err", 32'(err), 32'(aborted));
            chk("rnd_end_rv", 32'(rdat_valid), 32'(pend_rv));
            if (pend_rv) chk("rnd_end_rdat", rdat, pend_dat);
            $display("txn %0d: we=%0b addr=%h len=%0d beats=%0d abort=%0b",
                     t, tr_we, tr_addr, tr_len, aborted ? k : k + 1, aborted);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
